mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mdu_pkg.sv | 28 ++
 rtl/mdu_sign_fix.sv | 54 +++++
 rtl/mult_div_unit.sv | 184 ++++++++++++++++++
 tb/tb_mult_div_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide unit.
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } mdu_state_e;

  localparam int ITER_COUNT = 32;
  localparam int CNT_W      = $clog2(ITER_COUNT);

  function automatic logic op_is_div(input mdu_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input mdu_op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Operand magnitude extraction and result sign restoration (purely combinational).
module mdu_sign_fix
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  mdu_op_e          mag_op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] a_mag_o,
  output logic [WIDTH-1:0] b_mag_o,
  output logic             a_neg_o,
  output logic             b_neg_o,
  input  mdu_op_e          fix_op_i,
  input  logic             fix_a_neg_i,
  input  logic             fix_b_neg_i,
  input  logic [WIDTH-1:0] raw_hi_i,
  input  logic [WIDTH-1:0] raw_lo_i,
  output logic [WIDTH-1:0] res_hi_o,
  output logic [WIDTH-1:0] res_lo_o
);

  logic [2*WIDTH-1:0] prod_neg;

  assign prod_neg = -{raw_hi_i, raw_lo_i};

  // Unsigned ops see their operands unchanged; 0x80000000 negates to itself, i.e. 2^31.
  always_comb begin
    a_neg_o = op_is_signed(mag_op_i) & a_i[WIDTH-1];
    b_neg_o = op_is_signed(mag_op_i) & b_i[WIDTH-1];
    a_mag_o = a_neg_o ? -a_i : a_i;
    b_mag_o = b_neg_o ? -b_i : b_i;
  end

  // Product takes sign a^b; quotient takes a^b, remainder follows the dividend.
  always_comb begin
    res_hi_o = raw_hi_i;
    res_lo_o = raw_lo_i;
    case (fix_op_i)
      OP_MULT: begin
        if (fix_a_neg_i ^ fix_b_neg_i) begin
          res_hi_o = prod_neg[2*WIDTH-1:WIDTH];
          res_lo_o = prod_neg[WIDTH-1:0];
        end
      end
      OP_DIV: begin
        if (fix_a_neg_i ^ fix_b_neg_i) res_lo_o = -raw_lo_i;
        if (fix_a_neg_i)               res_hi_o = -raw_hi_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: one bit per cycle, result after 34 cycles.
//
// state   | meaning
// IDLE    | waiting for start; MTHI/MTLO writes accepted
// CALC    | 32 shift-add / restoring-divide iterations on magnitudes
// FIX     | sign restore, divide-by-zero override, hi/lo update
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] mt_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mdu_op_e          op_q, op_d;
  logic [WIDTH-1:0] rs_q, rs_d;
  logic             a_neg_q, a_neg_d;
  logic             b_neg_q, b_neg_d;
  logic             b_zero_q, b_zero_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] work_hi_q, work_hi_d;
  logic [WIDTH-1:0] work_lo_q, work_lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  mdu_op_e          op_in;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] fix_hi, fix_lo;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;

  assign op_in = mdu_op_e'(op);

  mdu_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .mag_op_i    (op_in),
    .a_i         (rs_data),
    .b_i         (rt_data),
    .a_mag_o     (a_mag),
    .b_mag_o     (b_mag),
    .a_neg_o     (a_neg),
    .b_neg_o     (b_neg),
    .fix_op_i    (op_q),
    .fix_a_neg_i (a_neg_q),
    .fix_b_neg_i (b_neg_q),
    .raw_hi_i    (work_hi_q),
    .raw_lo_i    (work_lo_q),
    .res_hi_o    (fix_hi),
    .res_lo_o    (fix_lo)
  );

  // Multiply: {work_hi, work_lo} shifts right, multiplier bits consumed from work_lo[0].
  // Divide: {work_hi, work_lo} shifts left, quotient bits enter at work_lo[0].
  // Remainder stays below the divisor, so the 33-bit trial's top bit is a true borrow.
  assign mul_sum   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, opnd_q} : '0);
  assign div_shift = {work_hi_q, work_lo_q[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, opnd_q};

  // Next-state, iteration datapath and hi/lo update.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    rs_d      = rs_q;
    a_neg_d   = a_neg_q;
    b_neg_d   = b_neg_q;
    b_zero_d  = b_zero_q;
    opnd_d    = opnd_q;
    work_hi_d = work_hi_q;
    work_lo_d = work_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_CALC;
          cnt_d     = CNT_W'(ITER_COUNT - 1);
          op_d      = op_in;
          rs_d      = rs_data;
          a_neg_d   = a_neg;
          b_neg_d   = b_neg;
          b_zero_d  = (rt_data == '0);
          work_hi_d = '0;
          if (op_is_div(op_in)) begin
            opnd_d    = b_mag;
            work_lo_d = a_mag;
          end else begin
            opnd_d    = a_mag;
            work_lo_d = b_mag;
          end
        end else begin
          if (hi_we) hi_d = mt_data;
          if (lo_we) lo_d = mt_data;
        end
      end
      ST_CALC: begin
        if (op_is_div(op_q)) begin
          work_hi_d = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
          work_lo_d = {work_lo_q[WIDTH-2:0], ~div_trial[WIDTH]};
        end else begin
          work_hi_d = mul_sum[WIDTH:1];
          work_lo_d = {mul_sum[0], work_lo_q[WIDTH-1:1]};
        end
        if (cnt_q == '0) state_d = ST_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        if (op_is_div(op_q) && b_zero_q) begin
          hi_d  = rs_q;
          lo_d  = '1;
          dbz_d = 1'b1;
        end else begin
          hi_d = fix_hi;
          lo_d = fix_lo;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= OP_MULT;
      rs_q      <= '0;
      a_neg_q   <= 1'b0;
      b_neg_q   <= 1'b0;
      b_zero_q  <= 1'b0;
      opnd_q    <= '0;
      work_hi_q <= '0;
      work_lo_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      rs_q      <= rs_d;
      a_neg_q   <= a_neg_d;
      b_neg_q   <= b_neg_d;
      b_zero_q  <= b_zero_d;
      opnd_q    <= opnd_d;
      work_hi_q <= work_hi_d;
      work_lo_q <= work_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: arithmetic reference model plus directed literal cases.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data, rt_data, mt_data;
  logic        hi_we, lo_we;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .mt_data     (mt_data),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Result of one operation as {div_by_zero, hi, lo}, from plain arithmetic.
  function automatic logic [64:0] model_calc(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (o)
      2'b00: begin p = sa * sb; return {1'b0, p}; end
      2'b01: begin p = ua * ub; return {1'b0, p}; end
      2'b10: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        return {1'b0, a % b, a / b};
      end
    endcase
  endfunction

  // Reference: accepted start -> busy for 33 cycles, then result with a one-cycle done.
  logic        m_busy, m_done, m_dbz;
  int          m_left;
  logic [31:0] m_hi, m_lo;
  logic [64:0] p_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_left <= 0; m_done <= 1'b0; m_dbz <= 1'b0;
      m_hi <= '0; m_lo <= '0; p_res <= '0;
    end else begin
      m_done <= 1'b0;
      m_dbz  <= 1'b0;
      if (m_busy) begin
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_dbz  <= p_res[64];
          m_hi   <= p_res[63:32];
          m_lo   <= p_res[31:0];
        end
        m_left <= m_left - 1;
      end else if (start) begin
        p_res  <= model_calc(op, rs_data, rt_data);
        m_busy <= 1'b1;
        m_left <= 33;
      end else begin
        if (hi_we) m_hi <= mt_data;
        if (lo_we) m_lo <= mt_data;
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the reference.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("cmp_busy", busy, m_busy);
      chk("cmp_done", done, m_done);
      chk("cmp_dbz", div_by_zero, m_dbz);
      chk("cmp_hi", hi, m_hi);
      chk("cmp_lo", lo, m_lo);
    end
  end

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic quiet();
    start   = 1'b0;
    hi_we   = 1'b0;
    lo_we   = 1'b0;
    op      = 2'($urandom);
    rs_data = $urandom;
    rt_data = $urandom;
    mt_data = $urandom;
  endtask

  task automatic scramble();
    quiet();
    start = ($urandom_range(0, 3) == 0);
    hi_we = 1'($urandom);
    lo_we = 1'($urandom);
  endtask

  // Called at a negedge; returns at the negedge of the done cycle (or timeout).
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit noisy, input int pulse_cyc);
    int lat;
    start   = 1'b1;
    op      = o;
    rs_data = a;
    rt_data = b;
    hi_we   = noisy ? 1'($urandom) : 1'b0;
    lo_we   = noisy ? 1'($urandom) : 1'b0;
    mt_data = $urandom;
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (done || lat >= 40) break;
      if (noisy) scramble();
      else begin
        quiet();
        if (lat == pulse_cyc) start = 1'b1;
      end
    end
    quiet();
    chk("latency", lat, 34);
  endtask

  initial begin
    rst_n = 1'b0;
    quiet();
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);

    rst_n  = 1'b1;
    chk_en = 1'b1;
    do_op(2'b01, 32'd7, 32'd6, 0, 0);
    chk("multu_hi", hi, 32'h0000_0000);
    chk("multu_lo", lo, 32'h0000_002A);

    do_op(2'b00, 32'hFFFF_FFFD, 32'd5, 0, 0);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFF1);

    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    do_op(2'b11, 32'd100, 32'd0, 0, 0);
    chk("dbz_flag", div_by_zero, 1);
    chk("dbz_hi", hi, 32'h0000_0064);
    chk("dbz_lo", lo, 32'hFFFF_FFFF);

    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'h0000_0000);
    chk("ovf_flag", div_by_zero, 0);

    do_op(2'b10, 32'hFFFF_FFF9, 32'd0, 0, 0);
    chk("sdbz_hi", hi, 32'hFFFF_FFF9);
    chk("sdbz_lo", lo, 32'hFFFF_FFFF);

    do_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0, 0);
    chk("minmin_hi", hi, 32'h4000_0000);
    chk("minmin_lo", lo, 32'h0000_0000);

    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    chk("maxu_hi", hi, 32'hFFFF_FFFE);
    chk("maxu_lo", lo, 32'h0000_0001);

    do_op(2'b10, 32'd7, 32'hFFFF_FFFE, 0, 0);
    chk("divneg_lo", lo, 32'hFFFF_FFFD);
    chk("divneg_hi", hi, 32'h0000_0001);

    // A second start in cycle 10 must be dropped.
    do_op(2'b01, 32'd2, 32'd3, 0, 10);
    chk("restart_lo", lo, 32'd6);
    repeat (5) @(negedge clk);
    chk("restart_idle", busy, 0);

    hi_we = 1'b1; mt_data = 32'hDEAD_BEEF;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; mt_data = 32'hCAFE_F00D;
    @(negedge clk);
    quiet();
    chk("mthi", hi, 32'hDEAD_BEEF);
    chk("mtlo", lo, 32'hCAFE_F00D);

    // Reset in cycle 15 of a divide, then restart in the first cycle after release.
    start = 1'b1; op = 2'b10; rs_data = 32'd1000; rt_data = 32'd7;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      quiet();
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(2'b01, 32'd9, 32'd9, 0, 0);
    chk("postrst_lo", lo, 32'd81);

    for (int i = 0; i < 60; i++) begin
      do_op(2'($urandom), pick(), pick(), 1, 0);
      repeat ($urandom_range(0, 3)) begin
        quiet();
        hi_we = 1'($urandom);
        lo_we = 1'($urandom);
        @(negedge clk);
      end
      quiet();
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
